// File: rtl/cam_pkg.sv
// Shared types and default widths for the camera sync decoder.
package cam_pkg;

  localparam int CAM_X_W = 12;
  localparam int CAM_Y_W = 11;

  typedef enum logic [1:0] {
    SYNC_WAIT   = 2'd0,
    VBLANK      = 2'd1,
    ACTIVE_LINE = 2'd2,
    HBLANK      = 2'd3
  } cam_sync_state_t;

endpackage

// File: rtl/edge_det.sv
// Registers a level and flags its rising and falling edges in the same cycle the new level arrives.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_lvl;

  always_ff @(posedge clk) begin
    if (rst) r_lvl <= 1'b0;
    else     r_lvl <= i_lvl;
  end

  assign o_rise = i_lvl & ~r_lvl;
  assign o_fall = ~i_lvl & r_lvl;

endmodule

// File: rtl/cam_sync_decoder.sv
// Camera VSYNC/HREF/pixel-strobe decoder: frame/line pulses, pixel coordinates,
// line/frame measurements and irregularity flags.
//
// state       | meaning
// SYNC_WAIT   | after reset, discarding a partial frame until VSYNC ends
// VBLANK      | between frames, waiting for the first HREF of a frame
// ACTIVE_LINE | HREF active, pixels counted
// HBLANK      | between lines of a frame
module cam_sync_decoder
  import cam_pkg::*;
#(
  parameter int   X_W       = CAM_X_W,
  parameter int   Y_W       = CAM_Y_W,
  parameter logic VSYNC_POL = 1'b1,
  parameter logic HREF_POL  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vsync_s,
  input  logic           href_s,
  input  logic           pix_stb,
  output logic           frame_start,
  output logic           frame_end,
  output logic           line_start,
  output logic           line_end,
  output logic           pix_vld,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic [X_W-1:0] line_len,
  output logic [Y_W-1:0] frame_lines,
  output logic           meas_vld,
  output logic           err_len,
  output logic           err_ovf
);

  cam_sync_state_t r_state;
  logic [X_W:0]    r_xcnt;
  logic [X_W-1:0]  r_ref_len;
  logic            r_first_line;

  logic           w_vs, w_hr;
  logic           w_vs_rise, w_vs_fall, w_hr_rise, w_hr_fall;
  logic           w_in_line, w_line_go, w_stb;
  logic           w_line_end, w_frame_end, w_x_ovf;
  logic [X_W:0]   w_xbase, w_xnext;
  logic [X_W-1:0] w_xidx, w_len;
  logic [Y_W-1:0] w_lines;

  assign w_vs = vsync_s ^ ~VSYNC_POL;
  assign w_hr = href_s ^ ~HREF_POL;

  edge_det u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .i_lvl  (w_vs),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  edge_det u_hr_edge (
    .clk    (clk),
    .rst    (rst),
    .i_lvl  (w_hr),
    .o_rise (w_hr_rise),
    .o_fall (w_hr_fall)
  );

  // A VSYNC rise beats a simultaneous HREF rise: that line is dropped.
  assign w_in_line   = (r_state == ACTIVE_LINE);
  assign w_line_go   = w_hr_rise & ~w_vs_rise & ((r_state == VBLANK) | (r_state == HBLANK));
  assign w_stb       = pix_stb & (w_in_line | w_line_go);
  assign w_line_end  = w_in_line & (w_vs_rise | w_hr_fall);
  assign w_frame_end = w_vs_rise & (w_in_line | (r_state == HBLANK));

  // Pixel count carries one extra bit so a line of exactly 2^X_W pixels is not an overflow.
  assign w_xbase = w_line_go ? '0 : r_xcnt;
  assign w_x_ovf = w_stb & w_xbase[X_W];
  assign w_xnext = (w_stb & ~w_xbase[X_W]) ? w_xbase + (X_W+1)'(1) : w_xbase;
  assign w_xidx  = w_xbase[X_W] ? '1 : w_xbase[X_W-1:0];
  assign w_len   = w_xnext[X_W] ? '1 : w_xnext[X_W-1:0];
  assign w_lines = (&pix_y) ? '1 : pix_y + Y_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SYNC_WAIT;
      r_xcnt       <= '0;
      r_ref_len    <= '0;
      r_first_line <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      line_start   <= 1'b0;
      line_end     <= 1'b0;
      pix_vld      <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      line_len     <= '0;
      frame_lines  <= '0;
      meas_vld     <= 1'b0;
      err_len      <= 1'b0;
      err_ovf      <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      line_end    <= w_line_end;
      frame_end   <= w_frame_end;
      meas_vld    <= w_frame_end;
      pix_vld     <= w_stb;
      r_xcnt      <= w_xnext;

      if (w_line_end) begin
        line_len     <= w_len;
        r_first_line <= 1'b0;
        if (r_first_line)            r_ref_len <= w_len;
        else if (w_len != r_ref_len) err_len   <= 1'b1;
      end
      if (w_frame_end) frame_lines <= w_lines;
      if (w_x_ovf)     err_ovf     <= 1'b1;

      case (r_state)
        SYNC_WAIT: begin
          if (w_vs_fall) r_state <= VBLANK;
        end
        VBLANK: begin
          if (w_line_go) begin
            r_state      <= ACTIVE_LINE;
            frame_start  <= 1'b1;
            line_start   <= 1'b1;
            pix_x        <= '0;
            pix_y        <= '0;
            err_len      <= 1'b0;
            err_ovf      <= 1'b0;
            r_first_line <= 1'b1;
          end
        end
        ACTIVE_LINE: begin
          if (w_vs_rise)      r_state <= VBLANK;
          else if (w_hr_fall) r_state <= HBLANK;
        end
        HBLANK: begin
          if (w_vs_rise) begin
            r_state <= VBLANK;
          end else if (w_hr_rise) begin
            r_state    <= ACTIVE_LINE;
            line_start <= 1'b1;
            pix_x      <= '0;
            if (&pix_y) err_ovf <= 1'b1;
            else        pix_y   <= pix_y + Y_W'(1);
          end
        end
        default: r_state <= SYNC_WAIT;
      endcase

      if (w_stb) pix_x <= w_xidx;
    end
  end

endmodule

// File: tb/tb_cam_sync_decoder.sv
// Bench for cam_sync_decoder: normal, inverted-polarity and narrow-X instances share one
// stimulus stream and are compared each cycle against a frame/line-level reference model.
module tb_cam_sync_decoder;

  localparam int YMAX = 2047;
  localparam int P_FS = 32, P_FE = 16, P_LS = 8, P_LE = 4, P_PV = 2, P_MV = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  bit   vs_l, hr_l, stb_l;
  logic vs_n, hr_n, vs_i, hr_i, stb_s;

  assign vs_n  = vs_l;
  assign hr_n  = hr_l;
  assign vs_i  = ~vs_l;
  assign hr_i  = ~hr_l;
  assign stb_s = stb_l;

  logic        a_fs, a_fe, a_ls, a_le, a_pv, a_mv, a_el, a_eo;
  logic [11:0] a_px, a_ll;
  logic [10:0] a_py, a_fl;
  logic        b_fs, b_fe, b_ls, b_le, b_pv, b_mv, b_el, b_eo;
  logic [11:0] b_px, b_ll;
  logic [10:0] b_py, b_fl;
  logic        c_fs, c_fe, c_ls, c_le, c_pv, c_mv, c_el, c_eo;
  logic [2:0]  c_px, c_ll;
  logic [10:0] c_py, c_fl;

  cam_sync_decoder dut (
    .clk(clk), .rst(rst), .vsync_s(vs_n), .href_s(hr_n), .pix_stb(stb_s),
    .frame_start(a_fs), .frame_end(a_fe), .line_start(a_ls), .line_end(a_le),
    .pix_vld(a_pv), .pix_x(a_px), .pix_y(a_py), .line_len(a_ll), .frame_lines(a_fl),
    .meas_vld(a_mv), .err_len(a_el), .err_ovf(a_eo)
  );

  cam_sync_decoder #(.VSYNC_POL(1'b0), .HREF_POL(1'b0)) dut_inv (
    .clk(clk), .rst(rst), .vsync_s(vs_i), .href_s(hr_i), .pix_stb(stb_s),
    .frame_start(b_fs), .frame_end(b_fe), .line_start(b_ls), .line_end(b_le),
    .pix_vld(b_pv), .pix_x(b_px), .pix_y(b_py), .line_len(b_ll), .frame_lines(b_fl),
    .meas_vld(b_mv), .err_len(b_el), .err_ovf(b_eo)
  );

  cam_sync_decoder #(.X_W(3)) dut_x3 (
    .clk(clk), .rst(rst), .vsync_s(vs_n), .href_s(hr_n), .pix_stb(stb_s),
    .frame_start(c_fs), .frame_end(c_fe), .line_start(c_ls), .line_end(c_le),
    .pix_vld(c_pv), .pix_x(c_px), .pix_y(c_py), .line_len(c_ll), .frame_lines(c_fl),
    .meas_vld(c_mv), .err_len(c_el), .err_ovf(c_eo)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: index 0 = 12-bit X instances, index 1 = 3-bit X instance.
  bit e_fs, e_fe, e_ls, e_le, e_pv, e_mv;
  int e_px[2];
  int m_ll[2], m_ref[2];
  bit m_el[2], m_eo[2];
  int m_py, m_fl, m_pix;
  bit m_first, m_synced, m_newframe;
  int f_lens[$];

  typedef struct {
    bit rst, vs, hr, stb;
    int pul, px, py, ll, fl;
    bit el, eo;
  } vec_t;
  vec_t tbl[19];

  function automatic int xmax(int k);
    return (k == 0) ? 4095 : 7;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(string tag, int k, int pul, int px, int py, int ll, int fl, int el, int eo);
    chk({tag, ".pulses"}, pul, int'({e_fs, e_fe, e_ls, e_le, e_pv, e_mv}));
    if (e_pv) chk({tag, ".pix_x"}, px, e_px[k]);
    chk({tag, ".pix_y"}, py, m_py);
    chk({tag, ".line_len"}, ll, m_ll[k]);
    chk({tag, ".frame_lines"}, fl, m_fl);
    chk({tag, ".err_len"}, el, int'(m_el[k]));
    chk({tag, ".err_ovf"}, eo, int'(m_eo[k]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cmp_dut("nrm", 0, int'({a_fs, a_fe, a_ls, a_le, a_pv, a_mv}), int'(a_px), int'(a_py),
            int'(a_ll), int'(a_fl), int'(a_el), int'(a_eo));
    cmp_dut("inv", 0, int'({b_fs, b_fe, b_ls, b_le, b_pv, b_mv}), int'(b_px), int'(b_py),
            int'(b_ll), int'(b_fl), int'(b_el), int'(b_eo));
    cmp_dut("x3", 1, int'({c_fs, c_fe, c_ls, c_le, c_pv, c_mv}), int'(c_px), int'(c_py),
            int'(c_ll), int'(c_fl), int'(c_el), int'(c_eo));
    {e_fs, e_fe, e_ls, e_le, e_pv, e_mv} = '0;
  endtask

  task automatic drive(bit v, bit h, bit s);
    vs_l  = v;
    hr_l  = h;
    stb_l = s;
  endtask

  task automatic m_start_line();
    e_ls = 1'b1;
    if (m_newframe) begin
      e_fs = 1'b1;
      m_newframe = 1'b0;
      m_py = 0;
      m_first = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_el[k] = 1'b0;
        m_eo[k] = 1'b0;
      end
    end else if (m_py == YMAX) begin
      m_eo[0] = 1'b1;
      m_eo[1] = 1'b1;
    end else begin
      m_py++;
    end
    m_pix = 0;
  endtask

  task automatic m_pixel();
    e_pv = 1'b1;
    for (int k = 0; k < 2; k++) begin
      e_px[k] = imin(m_pix, xmax(k));
      if (m_pix > xmax(k)) m_eo[k] = 1'b1;
    end
    m_pix++;
  endtask

  task automatic m_end_line();
    e_le = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_ll[k] = imin(m_pix, xmax(k));
      if (m_first)               m_ref[k] = m_ll[k];
      else if (m_ll[k] != m_ref[k]) m_el[k] = 1'b1;
    end
    m_first = 1'b0;
  endtask

  task automatic m_end_frame();
    e_fe = 1'b1;
    e_mv = 1'b1;
    m_fl = imin(m_py + 1, YMAX);
  endtask

  // Blanking cycles with random pixel strobes that must never be qualified.
  task automatic gap(int n, bit v, bit h);
    for (int i = 0; i < n; i++) begin
      drive(v, h, 1'($urandom % 2));
      tick();
    end
  endtask

  task automatic run_line(bit cnt, int npix, bit trunc);
    bit q[$];
    bit fall_stb;
    fall_stb = 1'b0;
    for (int p = 0; p < npix; p++) begin
      repeat ($urandom % 3) q.push_back(1'b0);
      q.push_back(1'b1);
    end
    if (q.size() == 0) q.push_back(1'b0);
    if (!trunc && q.size() > 1 && ($urandom % 2) == 1) fall_stb = q.pop_back();
    for (int i = 0; i < q.size(); i++) begin
      drive(1'b0, 1'b1, q[i]);
      if (cnt) begin
        if (i == 0) m_start_line();
        if (q[i]) m_pixel();
      end
      tick();
    end
    if (trunc) begin
      drive(1'b1, 1'b1, 1'b0);
      if (cnt) begin
        m_end_line();
        m_end_frame();
      end
    end else begin
      drive(1'b0, 1'b0, fall_stb);
      if (cnt) begin
        if (fall_stb) m_pixel();
        m_end_line();
      end
    end
    tick();
  endtask

  task automatic run_frame(int trunc_at, bit simul);
    bit cnt, truncd;
    cnt = m_synced;
    truncd = 1'b0;
    if (cnt) m_newframe = 1'b1;
    gap(1 + $urandom % 2, 1'b0, 1'b0);
    for (int li = 0; li < f_lens.size(); li++) begin
      if (li == trunc_at) begin
        run_line(cnt, f_lens[li], 1'b1);
        truncd = 1'b1;
        break;
      end
      run_line(cnt, f_lens[li], 1'b0);
      gap(1 + $urandom % 3, 1'b0, 1'b0);
    end
    if (!truncd) begin
      drive(1'b1, simul, 1'($urandom % 2));
      if (cnt) m_end_frame();
      tick();
    end
    gap(2 + $urandom % 3, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'($urandom % 2));
    tick();
    m_synced = 1'b1;
    gap(1 + $urandom % 2, 1'b0, 1'b0);
  endtask

  initial begin
    int n, tr;
    bit sm;

    tbl[0]  = '{1,0,0,0, 0,                 0,0,0,0, 0,0};
    tbl[1]  = '{0,1,0,0, 0,                 0,0,0,0, 0,0};
    tbl[2]  = '{0,0,0,0, 0,                 0,0,0,0, 0,0};
    tbl[3]  = '{0,0,1,1, P_FS|P_LS|P_PV,    0,0,0,0, 0,0};
    tbl[4]  = '{0,0,1,1, P_PV,              1,0,0,0, 0,0};
    tbl[5]  = '{0,0,1,0, 0,                 0,0,0,0, 0,0};
    tbl[6]  = '{0,0,0,1, P_LE|P_PV,         2,0,3,0, 0,0};
    tbl[7]  = '{0,0,1,0, P_LS,              0,1,3,0, 0,0};
    tbl[8]  = '{0,0,1,1, P_PV,              0,1,3,0, 0,0};
    tbl[9]  = '{1,0,1,1, 0,                 0,0,0,0, 0,0};
    tbl[10] = '{0,0,1,1, 0,                 0,0,0,0, 0,0};
    tbl[11] = '{0,0,0,0, 0,                 0,0,0,0, 0,0};
    tbl[12] = '{0,0,1,1, 0,                 0,0,0,0, 0,0};
    tbl[13] = '{0,1,0,0, 0,                 0,0,0,0, 0,0};
    tbl[14] = '{0,0,0,0, 0,                 0,0,0,0, 0,0};
    tbl[15] = '{0,0,1,1, P_FS|P_LS|P_PV,    0,0,0,0, 0,0};
    tbl[16] = '{0,0,0,0, P_LE,              0,0,1,0, 0,0};
    tbl[17] = '{0,1,0,0, P_FE|P_MV,         0,0,1,1, 0,0};
    tbl[18] = '{0,0,0,0, 0,                 0,0,1,1, 0,0};

    m_py = 0; m_fl = 0; m_pix = 0;
    m_synced = 1'b0; m_newframe = 1'b0; m_first = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_ll[k] = 0; m_ref[k] = 0; m_el[k] = 1'b0; m_eo[k] = 1'b0; e_px[k] = 0;
    end

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b0;

    // Partial frame after reset is discarded, then a clean 4x8 frame.
    f_lens = '{8, 8, 8};
    run_frame(-1, 1'b0);
    f_lens = '{8, 8, 8, 8};
    run_frame(-1, 1'b0);
    chk("basic.frame_lines", int'(a_fl), 4);
    chk("basic.line_len", int'(a_ll), 8);
    chk("basic.err_len", int'(a_el), 0);

    // Short second line: err_len held to frame end, cleared by the next frame.
    f_lens = '{8, 7, 8, 8};
    run_frame(-1, 1'b0);
    chk("short.err_len", int'(a_el), 1);
    f_lens = '{6, 6};
    run_frame(-1, 1'b0);
    chk("short.err_len_cleared", int'(a_el), 0);

    // VSYNC rises in the third line after 5 pixels.
    f_lens = '{8, 8, 5, 8};
    run_frame(2, 1'b0);
    chk("trunc.frame_lines", int'(a_fl), 3);
    chk("trunc.line_len", int'(a_ll), 5);

    // Ten-pixel lines saturate the 3-bit X counter.
    f_lens = '{10, 10, 3};
    run_frame(-1, 1'b0);
    chk("sat.err_ovf_x3", int'(c_eo), 1);
    chk("sat.err_ovf_x12", int'(a_eo), 0);
    chk("sat.line_len_x12", int'(a_ll), 3);

    // VSYNC and HREF rising together: frame ends, the line is ignored.
    f_lens = '{4, 4};
    run_frame(-1, 1'b1);
    chk("simul.frame_lines", int'(a_fl), 2);

    // Reset and resync vectors.
    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst;
      drive(tbl[i].vs, tbl[i].hr, tbl[i].stb);
      {e_fs, e_fe, e_ls, e_le, e_pv, e_mv} = 6'(tbl[i].pul);
      m_py = tbl[i].py;
      m_fl = tbl[i].fl;
      for (int k = 0; k < 2; k++) begin
        e_px[k] = tbl[i].px;
        m_ll[k] = tbl[i].ll;
        m_el[k] = tbl[i].el;
        m_eo[k] = tbl[i].eo;
      end
      tick();
    end
    rst = 1'b0;
    m_synced = 1'b1;

    for (int f = 0; f < 25; f++) begin
      f_lens.delete();
      n = 1 + int'($urandom % 6);
      for (int i = 0; i < n; i++) f_lens.push_back(1 + int'($urandom % 12));
      tr = (($urandom % 5) == 0) ? int'($urandom % n) : -1;
      sm = (tr < 0) && (($urandom % 6) == 0);
      run_frame(tr, sm);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
